// File: rtl/sensor_cfg_sequencer_if.sv
// Bus between the configuration sequencer, its register LUT, the I2C/SCCB write
// master and the status consumers in the image pipeline.
interface sensor_cfg_sequencer_if;
  logic        init_done;
  logic        cfg_restart;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    input  init_done, cfg_restart, lut_data, wr_ack, wr_err,
    output lut_index, wr_req, wr_addr, wr_data, cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    output init_done, cfg_restart, lut_data, wr_ack, wr_err,
    input  lut_index, wr_req, wr_addr, wr_data, cfg_busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/sensor_cfg_sequencer.sv
// Walks a register LUT after power-on delay, issuing one I2C/SCCB write per entry.
// Optional per-entry retry on write error/timeout is enabled with `define CFG_RETRY_EN.
module sensor_cfg_sequencer #(
  parameter logic [7:0]  LUT_SIZE      = 8'd200,
  parameter logic [15:0] SETTLE_CYCLES = 16'd500,
  parameter logic [23:0] ACK_TIMEOUT   = 24'd1000000
`ifdef CFG_RETRY_EN
  ,
  parameter logic [3:0]  RETRY_MAX     = 4'd3
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sensor_cfg_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, WAIT_ACK, SETTLE, DONE, FAIL} state_t;

  localparam logic [7:0]  LAST_INDEX  = LUT_SIZE - 8'd1;
  localparam logic [23:0] ACK_LIMIT   = ACK_TIMEOUT - 24'd1;
  localparam logic [15:0] SETTLE_LAST = SETTLE_CYCLES - 16'd1;

  state_t      state_reg;
  logic [7:0]  lut_index_reg;
  logic        wr_req_reg;
  logic [15:0] wr_addr_reg;
  logic [7:0]  wr_data_reg;
  logic        cfg_busy_reg;
  logic        cfg_done_reg;
  logic        cfg_err_reg;
  logic [23:0] ack_cnt_reg;
  logic [15:0] settle_cnt_reg;
`ifdef CFG_RETRY_EN
  logic [3:0]  retry_cnt_reg;
`endif

  logic [23:0] ack_cnt_next;
  logic        timeout_hit;
  logic        adv_done;
  logic [7:0]  adv_index;

  // The timeout fires when the incremented count reaches ACK_TIMEOUT-1, so the
  // REQ cycle itself is part of the ACK_TIMEOUT window.
  always_comb begin
    ack_cnt_next = (ack_cnt_reg == '1) ? ack_cnt_reg : ack_cnt_reg + 24'd1;
    timeout_hit  = (ack_cnt_next >= ACK_LIMIT);
    adv_done     = (lut_index_reg >= LAST_INDEX);
    adv_index    = adv_done ? lut_index_reg : lut_index_reg + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      lut_index_reg  <= '0;
      wr_req_reg     <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      cfg_busy_reg   <= 1'b0;
      cfg_done_reg   <= 1'b0;
      cfg_err_reg    <= 1'b0;
      ack_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
`ifdef CFG_RETRY_EN
      retry_cnt_reg  <= '0;
`endif
    end else begin
      wr_req_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.init_done) begin
            state_reg    <= FETCH;
            cfg_busy_reg <= 1'b1;
          end
        end
        FETCH: begin
          wr_addr_reg <= bus.lut_data[23:8];
          wr_data_reg <= bus.lut_data[7:0];
          wr_req_reg  <= 1'b1;
          state_reg   <= REQ;
`ifdef CFG_RETRY_EN
          retry_cnt_reg <= '0;
`endif
        end
        REQ: begin
          ack_cnt_reg <= '0;
          state_reg   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          ack_cnt_reg <= ack_cnt_next;
          // An error pulse wins over a simultaneous ack; an ack wins over the timeout.
          if (bus.wr_err || (timeout_hit && !bus.wr_ack)) begin
`ifdef CFG_RETRY_EN
            if (retry_cnt_reg < RETRY_MAX) begin
              retry_cnt_reg <= retry_cnt_reg + 4'd1;
              wr_req_reg    <= 1'b1;
              state_reg     <= REQ;
            end else begin
              state_reg    <= FAIL;
              cfg_err_reg  <= 1'b1;
              cfg_busy_reg <= 1'b0;
            end
`else
            state_reg    <= FAIL;
            cfg_err_reg  <= 1'b1;
            cfg_busy_reg <= 1'b0;
`endif
          end else if (bus.wr_ack) begin
            settle_cnt_reg <= '0;
            if (SETTLE_CYCLES != 16'd0) begin
              state_reg <= SETTLE;
            end else if (adv_done) begin
              state_reg    <= DONE;
              cfg_done_reg <= 1'b1;
              cfg_busy_reg <= 1'b0;
            end else begin
              state_reg     <= FETCH;
              lut_index_reg <= adv_index;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt_reg >= SETTLE_LAST) begin
            if (adv_done) begin
              state_reg    <= DONE;
              cfg_done_reg <= 1'b1;
              cfg_busy_reg <= 1'b0;
            end else begin
              state_reg     <= FETCH;
              lut_index_reg <= adv_index;
            end
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 16'd1;
          end
        end
        DONE, FAIL: begin
          if (bus.cfg_restart) begin
            state_reg     <= IDLE;
            cfg_done_reg  <= 1'b0;
            cfg_err_reg   <= 1'b0;
            lut_index_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.lut_index = lut_index_reg;
  assign bus.wr_req    = wr_req_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.cfg_busy  = cfg_busy_reg;
  assign bus.cfg_done  = cfg_done_reg;
  assign bus.cfg_err   = cfg_err_reg;

endmodule
